// File: rtl/mlx90640_i2c_responder.sv
// mlx90640_i2c_responder: MLX90640-style I2C target (16-bit pointer, 16-bit words) backed by an external RAM.
// Define MLX_RESP_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA (+2 cycles bus latency).
module mlx90640_i2c_responder #(
    parameter logic [6:0] p_slave_addr = 7'h33,
    parameter int         p_mem_aw     = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_scl,
    input  logic                i_sda,
    output logic                o_sda_oe,
    output logic                o_mem_re,
    output logic                o_mem_we,
    output logic [p_mem_aw-1:0] o_mem_addr,
    output logic [15:0]         o_mem_wdata,
    input  logic [15:0]         i_mem_rdata,
    output logic                o_busy,
    output logic                o_stop
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR_HI, PTR_HI_ACK, PTR_LO, PTR_LO_ACK,
        WR_BYTE, WR_ACK, RD_BYTE, RD_MACK
    } state_t;
    state_t      state;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl, sda, scl_d, sda_d;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift, hi_byte;
    logic [15:0] ptr, tx;
    logic        rw, lo_half, re_d;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i_scl};
            sda_sync <= {sda_sync[0], i_sda};
        end
    end
`ifdef MLX_RESP_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_h <= 2'b11;
            sda_h <= 2'b11;
            scl   <= 1'b1;
            sda   <= 1'b1;
        end else begin
            scl_h <= {scl_h[0], scl_sync[1]};
            sda_h <= {sda_h[0], sda_sync[1]};
            scl   <= (scl_sync[1] & scl_h[0]) | (scl_sync[1] & scl_h[1]) | (scl_h[0] & scl_h[1]);
            sda   <= (sda_sync[1] & sda_h[0]) | (sda_sync[1] & sda_h[1]) | (sda_h[0] & sda_h[1]);
        end
    end
`else
    assign scl = scl_sync[1];
    assign sda = sda_sync[1];
`endif
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl;
            sda_d <= sda;
        end
    end
    logic        scl_rise, scl_fall, start, stop, last, in_byte, ack_state;
    logic [7:0]  byte_in;
    logic [15:0] ptr_inc;
    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    assign start     = scl & scl_d & sda_d & ~sda;
    assign stop      = scl & scl_d & ~sda_d & sda;
    assign last      = &bit_cnt;
    assign byte_in   = {shift[6:0], sda};
    assign ptr_inc   = ptr + 16'd1;
    assign in_byte   = state == ADDR || state == PTR_HI || state == PTR_LO || state == WR_BYTE || state == RD_BYTE;
    assign ack_state = state == ADDR_ACK || state == PTR_HI_ACK || state == PTR_LO_ACK || state == WR_ACK;
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable) begin
            state    <= IDLE;
            o_sda_oe <= 1'b0;
            o_mem_re <= 1'b0;
            o_mem_we <= 1'b0;
            o_busy   <= 1'b0;
            o_stop   <= 1'b0;
            re_d     <= 1'b0;
            bit_cnt  <= '0;
            if (i_rst) begin
                o_mem_addr  <= '0;
                o_mem_wdata <= '0;
                ptr         <= '0;
                tx          <= '0;
                shift       <= '0;
                hi_byte     <= '0;
                rw          <= 1'b0;
                lo_half     <= 1'b0;
            end
        end else begin
            o_mem_re <= 1'b0;
            o_mem_we <= 1'b0;
            o_stop   <= 1'b0;
            re_d     <= o_mem_re;
            if (re_d) tx <= i_mem_rdata;
            if (stop) begin
                state    <= IDLE;
                o_sda_oe <= 1'b0;
                o_stop   <= o_busy;
                o_busy   <= 1'b0;
            end else if (start) begin
                state   <= ADDR;
                bit_cnt <= '0;
            end else if (scl_fall) begin
                o_sda_oe <= ack_state || (state == RD_BYTE && !tx[15]);
            end else if (scl_rise) begin
                shift   <= byte_in;
                bit_cnt <= in_byte ? bit_cnt + 3'd1 : 3'd0;
                case (state)
                    ADDR: if (last) begin
                        rw     <= byte_in[0];
                        state  <= byte_in[7:1] == p_slave_addr ? ADDR_ACK : IDLE;
                        o_busy <= byte_in[7:1] == p_slave_addr;
                        if (byte_in[7:1] == p_slave_addr && byte_in[0]) begin
                            o_mem_re   <= 1'b1;
                            o_mem_addr <= ptr[p_mem_aw-1:0];
                        end
                    end
                    ADDR_ACK: begin
                        state   <= rw ? RD_BYTE : PTR_HI;
                        lo_half <= 1'b0;
                    end
                    PTR_HI: if (last) begin
                        hi_byte <= byte_in;
                        state   <= PTR_HI_ACK;
                    end
                    PTR_HI_ACK: state <= PTR_LO;
                    PTR_LO: if (last) begin
                        ptr   <= {hi_byte, byte_in};
                        state <= PTR_LO_ACK;
                    end
                    PTR_LO_ACK: state <= WR_BYTE;
                    WR_BYTE: if (last) begin
                        state   <= WR_ACK;
                        lo_half <= !lo_half;
                        if (!lo_half) hi_byte <= byte_in;
                        else begin
                            o_mem_we    <= 1'b1;
                            o_mem_addr  <= ptr[p_mem_aw-1:0];
                            o_mem_wdata <= {hi_byte, byte_in};
                            ptr         <= ptr_inc;
                        end
                    end
                    WR_ACK: state <= WR_BYTE;
                    RD_BYTE: begin
                        tx <= {tx[14:0], 1'b0};
                        if (last) state <= RD_MACK;
                    end
                    RD_MACK: if (sda) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        state   <= RD_BYTE;
                        lo_half <= !lo_half;
                        if (lo_half) begin
                            ptr        <= ptr_inc;
                            o_mem_re   <= 1'b1;
                            o_mem_addr <= ptr_inc[p_mem_aw-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mlx90640_i2c_responder.sv
// tb_mlx90640_i2c_responder: directed I2C master driving the responder against a bench RAM model.
module tb_mlx90640_i2c_responder;
    localparam time Q = 100ns;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b1;
    logic        scl_m = 1'b1, sda_m = 1'b1;
    logic        sda_oe, mem_re, mem_we, busy, stop;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    wire         sda_line = sda_m & ~sda_oe;
    int          checks = 0, errors = 0;
    logic [15:0] ram [0:65535];
    logic [15:0] we_addr [0:63], we_data [0:63], re_addr [0:63];
    int          we_cnt = 0, re_cnt = 0, stop_cnt = 0, oe_cyc = 0, busy_cyc = 0;
    int          we0, re0, st0, oe0, bz0;
    logic        ack;
    logic [7:0]  d;

    mlx90640_i2c_responder #(.p_slave_addr(7'h33), .p_mem_aw(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_scl(scl_m), .i_sda(sda_line),
        .o_sda_oe(sda_oe), .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy), .o_stop(stop)
    );

    always #5ns clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_addr[we_cnt[5:0]] <= mem_addr;
            we_data[we_cnt[5:0]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (mem_re) begin
            mem_rdata <= ram[mem_addr];
            re_addr[re_cnt[5:0]] <= mem_addr;
            re_cnt <= re_cnt + 1;
        end
        if (stop) stop_cnt <= stop_cnt + 1;
        if (sda_oe) oe_cyc <= oe_cyc + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        we0 = we_cnt; re0 = re_cnt; st0 = stop_cnt; oe0 = oe_cyc; bz0 = busy_cyc;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q; #Q;
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_m = b; #Q; scl_m = 1'b1;
        if (glitch) begin
            #(Q / 2); scl_m = 1'b0; #10ns; scl_m = 1'b1; #(Q / 2 - 10ns);
        end else #Q;
        #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; a = ~sda_line; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #Q; scl_m = 1'b1; #Q; v = {v[6:0], sda_line}; #Q; scl_m = 1'b0; #Q;
        end
        send_bit(nack, 1'b0);
    endtask

    task automatic set_ptr(input logic [15:0] p, input string tag);
        i2c_start();
        write_byte(8'h66, ack); chk({tag, "_addr_ack"}, ack, 1);
        write_byte(p[15:8], ack); chk({tag, "_phi_ack"}, ack, 1);
        write_byte(p[7:0], ack); chk({tag, "_plo_ack"}, ack, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] wb [0:6];
        wb[0] = 8'h66; wb[1] = 8'h24; wb[2] = 8'h00; wb[3] = 8'h12;
        wb[4] = 8'h34; wb[5] = 8'hAB; wb[6] = 8'hCD;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_oe", sda_oe, 0); chk("rst_re", mem_re, 0); chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0); chk("rst_stop", stop, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // addressed write of two words
        snap();
        i2c_start();
        for (int i = 0; i < 7; i++) begin
            write_byte(wb[i], ack);
            chk($sformatf("wr_ack%0d", i), ack, 1);
        end
        chk("wr_busy", busy, 1);
        i2c_stop();
        chk("wr_we_cnt", we_cnt - we0, 2);
        chk("wr_addr0", we_addr[we0[5:0]], 16'h2400); chk("wr_data0", we_data[we0[5:0]], 16'h1234);
        chk("wr_addr1", we_addr[we0[5:0] + 6'd1], 16'h2401); chk("wr_data1", we_data[we0[5:0] + 6'd1], 16'hABCD);
        chk("wr_stop_cnt", stop_cnt - st0, 1); chk("wr_busy_end", busy, 0);

        // burst read across two words
        ram[16'h0400] = 16'h1111; ram[16'h0401] = 16'h2222;
        snap();
        set_ptr(16'h0400, "rd");
        i2c_start();
        write_byte(8'h67, ack); chk("rd_raddr_ack", ack, 1);
        read_byte(1'b0, d); chk("rd_b0", d, 8'h11);
        read_byte(1'b0, d); chk("rd_b1", d, 8'h11);
        read_byte(1'b0, d); chk("rd_b2", d, 8'h22);
        read_byte(1'b1, d); chk("rd_b3", d, 8'h22);
        i2c_stop();
        chk("rd_re_cnt", re_cnt - re0, 2);
        chk("rd_re_addr0", re_addr[re0[5:0]], 16'h0400); chk("rd_re_addr1", re_addr[re0[5:0] + 6'd1], 16'h0401);
        chk("rd_oe_end", sda_oe, 0);

        // address mismatch
        snap();
        i2c_start();
        write_byte(8'h68, ack); chk("mm_ack", ack, 0);
        write_byte(8'h00, ack); chk("mm_data_ack", ack, 0);
        i2c_stop();
        chk("mm_oe_cyc", oe_cyc - oe0, 0); chk("mm_busy_cyc", busy_cyc - bz0, 0);
        chk("mm_we", we_cnt - we0, 0); chk("mm_re", re_cnt - re0, 0); chk("mm_stop", stop_cnt - st0, 0);

        // status register read
        ram[16'h8000] = 16'h0009;
        set_ptr(16'h8000, "st");
        i2c_start();
        write_byte(8'h67, ack); chk("st_raddr_ack", ack, 1);
        read_byte(1'b0, d); chk("st_hi", d, 8'h00);
        read_byte(1'b1, d); chk("st_lo", d, 8'h09);
        i2c_stop();

        // pointer wrap
        snap();
        set_ptr(16'hFFFF, "wrap");
        write_byte(8'h11, ack); write_byte(8'h22, ack);
        write_byte(8'h33, ack); write_byte(8'h44, ack); chk("wrap_ack", ack, 1);
        i2c_stop();
        chk("wrap_we_cnt", we_cnt - we0, 2);
        chk("wrap_addr0", we_addr[we0[5:0]], 16'hFFFF); chk("wrap_data0", we_data[we0[5:0]], 16'h1122);
        chk("wrap_addr1", we_addr[we0[5:0] + 6'd1], 16'h0000); chk("wrap_data1", we_data[we0[5:0] + 6'd1], 16'h3344);

        // STOP after three data bits, then an unaddressed byte
        snap();
        set_ptr(16'h1234, "mid");
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        i2c_stop();
        chk("mid_we", we_cnt - we0, 0); chk("mid_stop", stop_cnt - st0, 1);
        chk("mid_busy", busy, 0); chk("mid_oe", sda_oe, 0);
        snap();
        write_byte(8'hFF, ack); chk("mid_idle_ack", ack, 0);
        chk("mid_idle_oe", oe_cyc - oe0, 0);

        // disabled block ignores the bus
        enable = 1'b0;
        i2c_start();
        write_byte(8'h66, ack); chk("dis_ack", ack, 0);
        i2c_stop();
        enable = 1'b1;

        // reset while driving a zero data bit
        ram[16'h0500] = 16'h0000;
        set_ptr(16'h0500, "rr");
        i2c_start();
        write_byte(8'h67, ack); chk("rr_raddr_ack", ack, 1);
        chk("rr_oe_drive", sda_oe, 1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rr_oe_released", sda_oe, 0); chk("rr_busy", busy, 0);
        @(negedge clk); rst = 1'b0;
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; #Q;

`ifdef MLX_RESP_GLITCH_FILTER_EN
        // a 1-cycle SCL low glitch inside a data bit must not shift an extra bit
        snap();
        set_ptr(16'h0600, "gl");
        for (int i = 7; i >= 0; i--) send_bit(i[0] ? 1'b1 : 1'b0, i == 5);
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; ack = ~sda_line; #Q; scl_m = 1'b0; #Q;
        chk("gl_ack", ack, 1);
        write_byte(8'h5A, ack);
        i2c_stop();
        chk("gl_we_cnt", we_cnt - we0, 1);
        chk("gl_data", we_data[we0[5:0]], 16'hAA5A);
`endif

        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mlx90640_i2c_responder.md
Name: mlx90640_i2c_responder

Overview:
- I2C target that emulates the MLX90640 bus interface; it is the responder end of the 16-bit-register I2C read/write protocol issued by the MLX controller and the I2C master wrapper.
- Decodes START/STOP, 7-bit address, 16-bit register pointer and 16-bit big-endian data words.
- Backs all registers with an external synchronous RAM port, so sim benches and loopback builds can model EEPROM, RAM frame data and the status register without a sensor.

Parameters:
- p_slave_addr, 'h33, 7-bit I2C address the block answers to.
- p_mem_aw, 16, width of the word address presented to the backing RAM; the low p_mem_aw bits of the register pointer are used.

Ports:
- i_clk  in  1  system clock; must be at least 20x SCL frequency.
- i_rst  in  1  synchronous active-high reset.
- i_enable  in  1  0 = ignore the bus, never drive SDA low, FSM held in IDLE.
- i_scl  in  1  SCL line level (async).
- i_sda  in  1  SDA line level (async).
- o_sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- o_mem_re  out  1  RAM read strobe, 1-cycle pulse.
- o_mem_we  out  1  RAM write strobe, 1-cycle pulse.
- o_mem_addr  out  p_mem_aw  RAM word address (register pointer).
- o_mem_wdata  out  16  RAM write word.
- i_mem_rdata  in  16  RAM read word, valid exactly 1 cycle after o_mem_re.
- o_busy  out  1  1 from an addressed START until STOP or NACK-release.
- o_stop  out  1  1-cycle pulse when STOP is detected after an addressed transaction.

Behaviour:
- Reset: o_sda_oe=0, o_mem_re=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_busy=0, o_stop=0, pointer=0, state IDLE. Reset mid-transfer releases SDA on the next cycle.
- Input path: 2-flop synchronizer on SCL and SDA, then 1 compare flop for edge detection.
  - START = SDA fall while SCL high; STOP = SDA rise while SCL high.
  - Bits are sampled on the synchronized SCL rise.
  - o_sda_oe changes only on the cycle after a synchronized SCL fall.
- States: IDLE, ADDR, ADDR_ACK, PTR_HI, PTR_HI_ACK, PTR_LO, PTR_LO_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_MACK.
- START in any state (including repeated START) -> ADDR with bit count 0. The pointer is kept.
- STOP in any state -> IDLE, SDA released. o_stop pulses if o_busy was 1.
- ADDR: shift 8 bits MSB first. If the upper 7 bits equal p_slave_addr -> ADDR_ACK and drive ACK (SDA low) for the 9th clock. On mismatch -> IDLE, no ACK, no drive until the next START.
- R/W=0 path: PTR_HI -> ACK -> PTR_LO -> ACK. The pointer loads {hi,lo} at the PTR_LO sample, then -> WR_BYTE.
  - WR_BYTE alternates hi/lo bytes, ACKing each.
  - After each lo byte: o_mem_we pulses with o_mem_addr=pointer and o_mem_wdata={hi,lo}, then pointer+1.
  - A trailing odd hi byte before STOP is discarded.
- R/W=1 path:
  - At ADDR_ACK entry, o_mem_re pulses with o_mem_addr=pointer; i_mem_rdata is latched into the tx shift register the next cycle.
  - RD_BYTE drives hi byte then lo byte, MSB first (oe = ~bit).
  - RD_MACK releases SDA and samples the master's bit. ACK after lo -> pointer+1, o_mem_re for the next word, back to RD_BYTE. ACK after hi -> send lo.
  - NACK -> release SDA and wait in IDLE for STOP/START.
- Pointer arithmetic: 16-bit, wraps 0xFFFF -> 0x0000. o_mem_addr = pointer[p_mem_aw-1:0].
- Simultaneous START and STOP cannot occur (SDA single edge). If a STOP and an SCL edge are detected in the same cycle, STOP wins.
- i_enable deasserted mid-transfer: release SDA on the next cycle, state -> IDLE.

Optional Feature:
- MLX_RESP_GLITCH_FILTER_EN
- Defined: a 3-sample majority filter follows each synchronizer. Pulses of 1 cycle are rejected, and all bus-event latencies grow by 2 cycles.
- Undefined: no filter; the synchronizer output goes directly to edge detection.

Test Plan:
- Addressed write: START, 0x66, 0x24, 0x00, 0x12, 0x34, 0xAB, 0xCD, STOP -> 7 ACKs; o_mem_we at addr 0x2400 data 0x1234, then at addr 0x2401 data 0xABCD; o_stop pulses once.
- Burst read: RAM preloaded 0x0400=0x1111, 0x0401=0x2222. Send START, 0x66, 0x04, 0x00, repeated START, 0x67, read 4 bytes with ACK, ACK, ACK, NACK, STOP -> bytes 0x11 0x11 0x22 0x22; o_mem_re at 0x0400 and 0x0401.
- Address mismatch: START, 0x68 -> SDA never driven; no mem strobes; o_busy stays 0.
- Status read at pointer 0x8000 with RAM value 0x0009 -> bytes 0x00 0x09; pointer wrap check: write pointer 0xFFFF, two words -> writes at 0xFFFF then 0x0000.
- STOP mid-byte after 3 data bits of a write -> no o_mem_we; state IDLE; SDA released.
- Reset asserted during RD_BYTE while driving low -> o_sda_oe=0 the next cycle. With MLX_RESP_GLITCH_FILTER_EN, a 1-cycle SCL low glitch causes no bit shift.
